// File: rtl/router_rd_port.sv
// Router read-side channel: FIFO, packet boundary tracking, stall timeout.
// One instance per destination port of the 1x3 router.
module router_rd_port #(
  parameter int DEPTH   = 16,
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 30
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             we,
  input  logic             lfd,
  input  logic [WIDTH-1:0] data_in,
  input  logic             read_enb,
  output logic             full,
  output logic             empty,
  output logic             valid_out,
  output logic [WIDTH-1:0] data_out,
  output logic             pkt_end,
  output logic             soft_reset
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT);

  logic [WIDTH:0]   mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic [6:0]       rem;
  logic [TW-1:0]    tcnt;

  logic [WIDTH:0]   rd_ent;
  logic [6:0]       hdr_len;
  logic             do_pop;
  logic             do_wr;
  logic             stall;
  logic             tmo;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);
  assign valid_out = !empty;

  assign rd_ent  = mem[rptr[AW-1:0]];
  // Header length field plus the trailing parity byte.
  assign hdr_len = {1'b0, rd_ent[7:2]} + 7'd1;

  assign stall  = valid_out && !read_enb;
  assign tmo    = stall && (tcnt == TW'(TIMEOUT - 1));
  assign do_pop = read_enb && !empty;
  // A pop in the same edge frees the slot of a full FIFO.
  assign do_wr  = we && (!full || do_pop) && !tmo;

  always_ff @(posedge clk) begin
    if (do_wr)
      mem[wptr[AW-1:0]] <= {lfd, data_in};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr       <= '0;
      rptr       <= '0;
      rem        <= '0;
      tcnt       <= '0;
      data_out   <= '0;
      pkt_end    <= 1'b0;
      soft_reset <= 1'b0;
    end else begin
      pkt_end    <= 1'b0;
      soft_reset <= 1'b0;
      if (tmo) begin
        wptr       <= '0;
        rptr       <= '0;
        rem        <= '0;
        tcnt       <= '0;
        data_out   <= '0;
        soft_reset <= 1'b1;
      end else begin
        if (do_wr)
          wptr <= wptr + 1'b1;
        if (do_pop) begin
          rptr     <= rptr + 1'b1;
          data_out <= rd_ent[WIDTH-1:0];
          pkt_end  <= (rem == 7'd1);
          if (rd_ent[WIDTH])
            rem <= hdr_len;
          else if (rem != 7'd0)
            rem <= rem - 7'd1;
        end
        tcnt <= stall ? tcnt + 1'b1 : '0;
      end
    end
  end

endmodule
